// File: rtl/dcache_pkg.sv
// dcache_pkg: FSM state encodings, cache geometry helpers and byte-address
// field extraction shared by the data-cache controller and its storage array.
package dcache_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_REFILL = 2'd1;
   localparam state_t ST_WRITE  = 2'd2;

   function automatic int f_idx_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int f_off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int f_tag_w(input int addr_w, input int lines, input int line_words);
      return addr_w - $clog2(lines) - $clog2(line_words) - 2;
   endfunction

   // Generic right-justified field pick; callers cast the result to the field width.
   function automatic logic [63:0] f_field(input logic [63:0] addr, input int lsb, input int width);
      logic [63:0] w_mask;
      w_mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return (addr >> lsb) & w_mask;
   endfunction

   function automatic logic [63:0] f_addr_tag(input logic [63:0] addr, input int idx_w,
                                              input int off_w, input int tag_w);
      return f_field(addr, idx_w + off_w + 2, tag_w);
   endfunction

   function automatic logic [63:0] f_addr_idx(input logic [63:0] addr, input int idx_w,
                                              input int off_w);
      return f_field(addr, off_w + 2, idx_w);
   endfunction

   function automatic logic [63:0] f_addr_off(input logic [63:0] addr, input int off_w);
      return f_field(addr, 2, off_w);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: direct-mapped valid/tag/data storage with a combinational read
// port, one word-write port and one tag/valid-write port; valid bits clear on rst.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int LINES      = 16,
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = 4,
   parameter int OFF_W      = 2,
   parameter int TAG_W      = 26
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  i_rd_idx,
   input  logic [OFF_W-1:0]  i_rd_off,
   output logic              o_rd_valid,
   output logic [TAG_W-1:0]  o_rd_tag,
   output logic [31:0]       o_rd_data,
   input  logic              i_wd_we,
   input  logic [IDX_W-1:0]  i_wd_idx,
   input  logic [OFF_W-1:0]  i_wd_off,
   input  logic [31:0]       i_wd_data,
   input  logic              i_tv_we,
   input  logic [IDX_W-1:0]  i_tv_idx,
   input  logic [TAG_W-1:0]  i_tv_tag
);

   logic [LINES-1:0] r_valid;
   logic [TAG_W-1:0] r_tag  [LINES];
   logic [31:0]      r_data [LINES*LINE_WORDS];

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_data  = r_data[{i_rd_idx, i_rd_off}];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
      end else if (i_tv_we) begin
         r_valid[i_tv_idx] <= 1'b1;
      end
   end

   // Tag and data contents are deliberately left uninitialised; valid gates them.
   always_ff @(posedge clk) begin
      if (!rst && i_tv_we) begin
         r_tag[i_tv_idx] <= i_tv_tag;
      end
      if (!rst && i_wd_we) begin
         r_data[{i_wd_idx, i_wd_off}] <= i_wd_data;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through, no-write-allocate data cache controller.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
//
// state     | meaning
// ST_IDLE   | serve read hits combinationally, accept stores and read misses
// ST_REFILL | fetch LINE_WORDS words of the missing line from memory
// ST_WRITE  | write-through of one store word to memory
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int LINES      = 16,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cache_busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);

   localparam int IDX_W = f_idx_w(LINES);
   localparam int OFF_W = f_off_w(LINE_WORDS);
   localparam int TAG_W = f_tag_w(ADDR_W, LINES, LINE_WORDS);
   localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);

   state_t            r_state;
   logic [TAG_W-1:0]  r_tag;
   logic [IDX_W-1:0]  r_idx;
   logic [OFF_W-1:0]  r_cnt;
   logic              r_wr_done;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;

   logic [TAG_W-1:0]  w_tag;
   logic [IDX_W-1:0]  w_idx;
   logic [OFF_W-1:0]  w_off;
   logic [OFF_W-1:0]  w_cnt_nxt;
   logic              w_valid;
   logic [TAG_W-1:0]  w_rd_tag;
   logic [31:0]       w_rd_data;
   logic              w_hit;
   logic              w_idle;
   logic              w_wr_act;
   logic              w_refill_ack;
   logic              w_wd_we;
   logic [IDX_W-1:0]  w_wd_idx;
   logic [OFF_W-1:0]  w_wd_off;
   logic [31:0]       w_wd_data;
   logic              w_tv_we;

   assign w_tag = TAG_W'(f_addr_tag(64'(cpu_addr), IDX_W, OFF_W, TAG_W));
   assign w_idx = IDX_W'(f_addr_idx(64'(cpu_addr), IDX_W, OFF_W));
   assign w_off = OFF_W'(f_addr_off(64'(cpu_addr), OFF_W));
   assign w_cnt_nxt = r_cnt + 1'b1;

   assign w_hit  = w_valid && (w_rd_tag == w_tag);
   assign w_idle = (r_state == ST_IDLE);
   // A store already written through is not re-issued while the pipeline still holds cpu_wr.
   assign w_wr_act = cpu_wr && !r_wr_done;

   assign cache_busy = !w_idle || w_wr_act || (cpu_rd && !w_hit);
   assign cpu_rdata  = (!rst && w_idle && cpu_rd && w_hit) ? w_rd_data : 32'h0;

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   assign w_refill_ack = (r_state == ST_REFILL) && mem_ack;
   assign w_wd_we   = w_refill_ack || (w_idle && w_wr_act && w_hit);
   assign w_wd_idx  = w_refill_ack ? r_idx : w_idx;
   assign w_wd_off  = w_refill_ack ? r_cnt : w_off;
   assign w_wd_data = w_refill_ack ? mem_rdata : cpu_wdata;
   assign w_tv_we   = w_refill_ack && (r_cnt == CNT_LAST);

   dcache_array #(
      .LINES      (LINES),
      .LINE_WORDS (LINE_WORDS),
      .IDX_W      (IDX_W),
      .OFF_W      (OFF_W),
      .TAG_W      (TAG_W)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .i_rd_idx   (w_idx),
      .i_rd_off   (w_off),
      .o_rd_valid (w_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_data  (w_rd_data),
      .i_wd_we    (w_wd_we),
      .i_wd_idx   (w_wd_idx),
      .i_wd_off   (w_wd_off),
      .i_wd_data  (w_wd_data),
      .i_tv_we    (w_tv_we),
      .i_tv_idx   (r_idx),
      .i_tv_tag   (r_tag)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_wr_done   <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         if (!cpu_wr) begin
            r_wr_done <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_wr_act) begin
                  r_state     <= ST_WRITE;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                  r_mem_wdata <= cpu_wdata;
               end else if (cpu_rd && !w_hit) begin
                  r_state    <= ST_REFILL;
                  r_cnt      <= '0;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}, 2'b00};
               end
            end
            ST_REFILL: begin
               if (mem_ack) begin
                  r_cnt <= w_cnt_nxt;
                  if (r_cnt == CNT_LAST) begin
                     r_state   <= ST_IDLE;
                     r_mem_req <= 1'b0;
                  end else begin
                     r_mem_addr <= {r_tag, r_idx, w_cnt_nxt, 2'b00};
                  end
               end
            end
            ST_WRITE: begin
               if (mem_ack) begin
                  r_state   <= ST_IDLE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_wr_done <= cpu_wr;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_mem_req <= 1'b0;
               r_mem_we  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_idle && !w_wr_act && cpu_rd && !w_hit) begin
         r_tag <= w_tag;
         r_idx <= w_idx;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (cpu_rd && w_hit && !cache_busy && (r_hit_cnt != 32'hFFFF_FFFF)) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (w_idle && !w_wr_act && cpu_rd && !w_hit && (r_miss_cnt != 32'hFFFF_FFFF)) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl; expected memory transactions
// are queued as requests are driven and checked by a responding memory model.
module tb_dcache_ctrl;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cache_busy;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int lat      = 0;
   int wait_cnt = 0;
   logic mem_en = 1'b0;

   txn_t        sb_q[$];
   logic [31:0] mem_img [logic [31:0]];
   logic        m_valid [16];
   logic [23:0] m_tag   [16];

   always #5 clk = ~clk;

   dcache_ctrl u_dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_rd     (cpu_rd),
      .cpu_wr     (cpu_wr),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cache_busy (cache_busy),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (mem_img.exists(a)) return mem_img[a];
      if (a[31:4] == 28'h10) return 32'hA0 + {28'h0, a[3:2]};
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory model: checks every cycle of an outstanding request against the queue head.
   always @(negedge clk) begin
      mem_ack = 1'b0;
      if (mem_en && mem_req && !rst) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_req", {31'h0, mem_req}, 32'h0);
         end else begin
            chk("mem_we", {31'h0, mem_we}, {31'h0, sb_q[0].we});
            chk("mem_addr", mem_addr, sb_q[0].addr);
            if (sb_q[0].we) chk("mem_wdata", mem_wdata, sb_q[0].wdata);
            if (wait_cnt >= lat) begin
               mem_ack  = 1'b1;
               wait_cnt = 0;
               if (mem_we) mem_img[mem_addr] = mem_wdata;
               else        mem_rdata = mem_val(mem_addr);
               void'(sb_q.pop_front());
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   task automatic do_read(input logic [31:0] addr, input int lat_i);
      logic [3:0]  idx;
      logic [23:0] tag;
      logic        miss;
      logic [31:0] base;
      int          stall;
      idx  = addr[7:4];
      tag  = addr[31:8];
      miss = !(m_valid[idx] && (m_tag[idx] == tag));
      base = {addr[31:4], 4'h0};
      lat  = lat_i;
      if (miss) begin
         for (int i = 0; i < 4; i++) sb_q.push_back('{1'b0, base + 32'(i * 4), 32'h0});
      end
      @(posedge clk); #2;
      cpu_rd   = 1'b1;
      cpu_addr = addr;
      stall    = 0;
      @(negedge clk);
      chk("rd_busy_first", {31'h0, cache_busy}, {31'h0, miss});
      for (int c = 0; c < 200 && cache_busy; c++) begin
         stall++;
         @(negedge clk);
      end
      chk("rd_timeout", {31'h0, cache_busy}, 32'h0);
      chk("rd_stall", 32'(stall), miss ? 32'(4 * (lat_i + 1) + 1) : 32'h0);
      chk("rd_data", cpu_rdata, mem_val(addr & ~32'h3));
      if (!miss) chk("rd_hit_noreq", {31'h0, mem_req}, 32'h0);
      chk("rd_sb_empty", 32'(sb_q.size()), 32'h0);
      if (miss) begin
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
      end
      @(posedge clk); #2;
      cpu_rd = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int lat_i);
      int c;
      lat = lat_i;
      sb_q.push_back('{1'b1, {addr[31:2], 2'b00}, data});
      @(posedge clk); #2;
      cpu_wr    = 1'b1;
      cpu_addr  = addr;
      cpu_wdata = data;
      @(negedge clk);
      chk("wr_busy", {31'h0, cache_busy}, 32'h1);
      c = 0;
      do begin
         @(posedge clk);
         c++;
      end while (!mem_ack && c < 50);
      chk("wr_ack_seen", {31'h0, mem_ack}, 32'h1);
      @(negedge clk);
      chk("wr_req_drop", {31'h0, mem_req}, 32'h0);
      @(posedge clk); #2;
      cpu_wr = 1'b0;
      @(negedge clk);
      chk("wr_busy_low", {31'h0, cache_busy}, 32'h0);
      chk("wr_no_reissue", {31'h0, mem_req}, 32'h0);
      chk("wr_sb_empty", 32'(sb_q.size()), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;
      int c;
      rst       = 1'b1;
      cpu_rd    = 1'b0;
      cpu_wr    = 1'b0;
      cpu_addr  = 32'h0;
      cpu_wdata = 32'h0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 24'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'h0, cache_busy}, 32'h0);
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      @(posedge clk); #2;
      rst    = 1'b0;
      mem_en = 1'b1;

      do_read(32'h0000_0104, 0);
      do_read(32'h0000_010C, 0);
      do_read(32'h0000_0204, 1);
      do_read(32'h0000_0104, 2);
      do_write(32'h0000_0108, 32'hDEAD_BEEF, 0);
      do_read(32'h0000_0108, 0);
      do_write(32'h0000_0300, 32'h0000_0055, 1);
      do_read(32'h0000_0300, 0);
      do_read(32'h0000_03F8, 0);
      do_read(32'h0000_0304, 0);

      // Reset in the middle of a refill after two words have been returned.
      lat = 0;
      for (int i = 0; i < 4; i++) sb_q.push_back('{1'b0, 32'h0000_0500 + 32'(i * 4), 32'h0});
      @(posedge clk); #2;
      cpu_rd   = 1'b1;
      cpu_addr = 32'h0000_0504;
      acks = 0;
      c    = 0;
      while (acks < 2 && c < 50) begin
         @(posedge clk);
         c++;
         if (mem_ack) acks++;
      end
      chk("rst_mid_acks", 32'(acks), 32'd2);
      #2;
      rst    = 1'b1;
      mem_en = 1'b0;
      cpu_rd = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mid_busy", {31'h0, cache_busy}, 32'h0);
      sb_q.delete();
      wait_cnt = 0;
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      @(posedge clk); #2;
      rst    = 1'b0;
      mem_en = 1'b1;
      do_read(32'h0000_0504, 0);
      do_read(32'h0000_0304, 1);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
